// File: rtl/filter_pkg.sv
// filter_pkg: shared helpers for the filter output stage.
//   round_sat    - round-half-up and saturate an unsigned sample down by S bits
//   FIFO_AW/CW   - pointer and count widths for the default output FIFO depth
package filter_pkg;

    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned FIFO_AW        = $clog2(FIFO_DEPTH_DEF);
    localparam int unsigned FIFO_CW        = FIFO_AW + 1;

    // din is zero-extended into 64 bits; dw is its true width, s the number
    // of LSBs removed (s >= 1, dw <= 63). Result occupies the low dw-s bits.
    // A carry out of bit dw-1 after adding the half-LSB means saturation.
    function automatic logic [63:0] round_sat(input logic [63:0] din,
                                              input int unsigned dw,
                                              input int unsigned s);
        logic [63:0] t;
        logic [63:0] ones;
        t    = din + (64'd1 << (s - 1));
        ones = (64'd1 << (dw - s)) - 64'd1;
        if ((t >> dw) != 64'd0) begin
            return ones;
        end
        return (t >> s) & ones;
    endfunction

endpackage

// File: rtl/filter_sync_fifo.sv
// filter_sync_fifo: single-clock FIFO with pointers and an occupancy count.
//   clk, reset_n : clock, synchronous active-low reset
//   push, din    : write request and data (ignored when full unless popping)
//   pop          : read request (ignored when empty)
//   dout         : head entry, combinational from storage; 0 when empty
//   full, empty  : occupancy flags
module filter_sync_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/filter_decimator.sv
// filter_decimator: keeps 1 of every decim_ratio filter samples, rounds and
// saturates them to OUT_WIDTH, and queues them for a ready/valid consumer.
//   clk, reset_n        : clock, synchronous active-low reset
//   decim_ratio         : keep 1 of N samples (0 behaves as 1)
//   y_N, y_N_valid      : input stream, no backpressure
//   z_N, z_N_valid      : FIFO head and non-empty flag
//   z_N_ready           : consumer accepts z_N when valid and ready
//   overflow            : sticky, a kept sample was dropped on a full FIFO
//   overflow_clr        : clears overflow (a simultaneous drop wins)
module filter_decimator
    import filter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH   = 12,
    parameter int unsigned RATIO_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [RATIO_WIDTH-1:0] decim_ratio,
    input  logic [DATA_WIDTH-1:0]  y_N,
    input  logic                   y_N_valid,
    output logic [OUT_WIDTH-1:0]   z_N,
    output logic                   z_N_valid,
    input  logic                   z_N_ready,
    output logic                   overflow,
    input  logic                   overflow_clr
);

    localparam int unsigned S = DATA_WIDTH - OUT_WIDTH;

    logic [RATIO_WIDTH-1:0] cnt;
    logic [RATIO_WIDTH-1:0] ratio_eff;
    logic                   keep;
    logic [OUT_WIDTH-1:0]   rnd_next;
    logic [OUT_WIDTH-1:0]   rnd_data;
    logic                   rnd_valid;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   push;
    logic                   drop;

    assign ratio_eff = (decim_ratio == '0) ? RATIO_WIDTH'(1) : decim_ratio;
    assign keep      = y_N_valid && (cnt == '0);
    assign rnd_next  = OUT_WIDTH'(round_sat(64'(y_N), DATA_WIDTH, S));

    // The >= compare lets a shrinking ratio pull cnt back to 0 on the next sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (y_N_valid) begin
            cnt <= (cnt >= ratio_eff - 1'b1) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
        end else begin
            rnd_valid <= keep;
            if (keep) begin
                rnd_data <= rnd_next;
            end
        end
    end

    assign pop  = z_N_valid && z_N_ready;
    assign push = rnd_valid && (!fifo_full || pop);
    assign drop = rnd_valid && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    filter_sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (rnd_data),
        .dout    (z_N),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign z_N_valid = !fifo_empty;

endmodule

// File: tb/tb_filter_decimator.sv
module tb_filter_decimator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  decim_ratio;
    logic [15:0] y_N;
    logic        y_N_valid;
    logic [11:0] z_N;
    logic        z_N_valid;
    logic        z_N_ready;
    logic        overflow;
    logic        overflow_clr;

    typedef struct {
        logic [11:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    filter_decimator #(
        .DATA_WIDTH  (16),
        .OUT_WIDTH   (12),
        .RATIO_WIDTH (4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .decim_ratio  (decim_ratio),
        .y_N          (y_N),
        .y_N_valid    (y_N_valid),
        .z_N          (z_N),
        .z_N_valid    (z_N_valid),
        .z_N_ready    (z_N_ready),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted output is matched against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && z_N_valid && z_N_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output z_N=%h expected no output", z_N);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (z_N !== e.data) begin
                    errors++;
                    $display("FAIL z_N_data got %h expected %h (cycle %0d)", z_N, e.data, cyc);
                end
                if (e.due >= 0) begin
                    checks++;
                    if (cyc != e.due) begin
                        errors++;
                        $display("FAIL z_N_latency data %h got cycle %0d expected cycle %0d",
                                 e.data, cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        y_N_valid = 1'b0;
    endtask

    // Drive a sample in the current cycle; if kept, queue its expected output.
    task automatic drive(input logic [15:0] v, input bit keep,
                         input logic [11:0] exp, input bit lat);
        exp_t e;
        y_N       = v;
        y_N_valid = 1'b1;
        if (keep) begin
            e.data = exp;
            e.due  = lat ? cyc + 2 : -1;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [15:0] v, input bit keep,
                        input logic [11:0] exp, input bit lat);
        step();
        drive(v, keep, exp, lat);
    endtask

    task automatic drain(input string name);
        int n = 0;
        z_N_ready = 1'b1;
        step();
        while ((sb.size() != 0 || z_N_valid) && n < 40) begin
            step();
            n++;
        end
        chk({name, "_drain_done"}, {31'd0, (n < 40)}, 32'd1);
        chk({name, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        decim_ratio  = 4'd1;
        y_N          = '0;
        y_N_valid    = 1'b0;
        z_N_ready    = 1'b0;
        overflow_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, z_N_valid}, 32'd0);
        chk("reset_z", {20'd0, z_N}, 32'd0);
        chk("reset_ovf", {31'd0, overflow}, 32'd0);
        reset_n = 1'b1;

        // Rounding and saturation at R=1, each output two cycles after its input.
        z_N_ready = 1'b1;
        send(16'h1237, 1, 12'h123, 1);
        send(16'h1238, 1, 12'h124, 1);
        send(16'hFFF8, 1, 12'hFFF, 1);
        send(16'h0000, 1, 12'h000, 1);
        drain("round");

        // R=3, contiguous then gapped input.
        decim_ratio = 4'd3;
        for (int i = 0; i < 9; i++)
            send(16'((i + 1) * 16), (i % 3) == 0, 12'(i + 1), 0);
        drain("decim");
        for (int i = 0; i < 9; i++) begin
            send(16'((i + 1) * 16), (i % 3) == 0, 12'(i + 1), 0);
            step();
        end
        drain("decim_gap");

        // R=8 until cnt=5, then R=2: sample 6 wraps, sample 7 is kept.
        decim_ratio = 4'd8;
        for (int i = 1; i <= 5; i++)
            send(16'(i * 256), i == 1, 12'(i * 16), 0);
        step();
        decim_ratio = 4'd2;
        drive(16'h0600, 0, 12'h000, 0);
        send(16'h0700, 1, 12'h070, 0);
        send(16'h0800, 0, 12'h000, 0);
        send(16'h0900, 1, 12'h090, 0);
        send(16'h0A00, 0, 12'h000, 0);
        drain("ratio");

        // Backpressure with R=0 (acts as 1): 4 queued, 2 dropped.
        decim_ratio = 4'd0;
        z_N_ready   = 1'b0;
        for (int i = 1; i <= 6; i++)
            send(16'(i * 16), i <= 4, 12'(i), 0);
        repeat (3) step();
        chk("bp_ovf_set", {31'd0, overflow}, 32'd1);
        chk("bp_valid", {31'd0, z_N_valid}, 32'd1);
        chk("bp_head", {20'd0, z_N}, 32'h001);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        step();
        chk("bp_ovf_clr", {31'd0, overflow}, 32'd0);
        drain("bp");

        // Full FIFO with push and pop in the same cycle.
        z_N_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(16'((10 + i) * 16), 1, 12'(10 + i), 0);
        send(16'h00E0, 1, 12'h00E, 0);
        step();
        z_N_ready = 1'b1;
        step();
        z_N_ready = 1'b0;
        chk("fp_no_drop", {31'd0, overflow}, 32'd0);
        chk("fp_valid", {31'd0, z_N_valid}, 32'd1);
        chk("fp_head", {20'd0, z_N}, 32'h00B);

        // Drop coinciding with overflow_clr: set wins.
        overflow_clr = 1'b1;
        send(16'h00F0, 0, 12'h000, 0);
        step();
        step();
        overflow_clr = 1'b0;
        chk("clr_drop_ovf", {31'd0, overflow}, 32'd1);
        step();
        chk("clr_drop_hold", {31'd0, overflow}, 32'd1);

        // Reset mid-stream with 3 queued entries and one in flight.
        step();
        z_N_ready = 1'b1;
        step();
        z_N_ready = 1'b0;
        send(16'h0300, 0, 12'h000, 0);
        step();
        reset_n = 1'b0;
        step();
        step();
        sb.delete();
        reset_n = 1'b1;
        chk("rst_valid", {31'd0, z_N_valid}, 32'd0);
        chk("rst_z", {20'd0, z_N}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        step();
        chk("rst_no_stale", {31'd0, z_N_valid}, 32'd0);
        decim_ratio = 4'd3;
        z_N_ready   = 1'b1;
        drive(16'h0555, 1, 12'h055, 1);
        send(16'h0666, 0, 12'h000, 0);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule

// File: doc/filter_decimator.md
# filter_decimator

Output stage placed directly downstream of the moving-average filter. It consumes the filter's `y_N`/`y_N_valid` stream, keeps one of every `decim_ratio` samples, and rounds and saturates each kept sample from `DATA_WIDTH` to `OUT_WIDTH`. Kept samples are buffered in a small FIFO and presented to the consumer over a ready/valid handshake. The filter cannot stall, so a full FIFO drops samples and raises a sticky overflow flag.

## Interface
- `DATA_WIDTH`, 16: input sample width (unsigned); must match the filter.
- `OUT_WIDTH`, 12: output sample width; must satisfy 1 ≤ `OUT_WIDTH` < `DATA_WIDTH`.
- `RATIO_WIDTH`, 4: width of `decim_ratio`.
- `FIFO_DEPTH`, 4: output FIFO entries; must be a power of 2, ≥ 2.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `decim_ratio` in `RATIO_WIDTH`: keep 1 of N samples; 0 is treated as 1.
- `y_N` in `DATA_WIDTH`: sample from the filter.
- `y_N_valid` in 1: `y_N` is valid this cycle; there is no backpressure toward the filter.
- `z_N` out `OUT_WIDTH`: FIFO head.
- `z_N_valid` out 1: FIFO is non-empty.
- `z_N_ready` in 1: consumer accepts `z_N` when both `z_N_valid` and `z_N_ready` are high.
- `overflow` out 1: sticky flag; a kept sample was dropped.
- `overflow_clr` in 1: clears `overflow`.

## Operation
- **Phase counter `cnt`** (`RATIO_WIDTH` bits) advances only on cycles with `y_N_valid`.
  - The sample is kept when `cnt == 0`.
  - Next value: `cnt <= (cnt >= R-1) ? 0 : cnt+1`, where R = max(`decim_ratio`, 1).
  - `decim_ratio` may change at any time. The `>=` compare guarantees wrap to 0 within one sample when R shrinks below `cnt`.
  - R = 1 keeps every sample.
- **Round/saturate**, with S = `DATA_WIDTH` − `OUT_WIDTH`:
  - Compute t = `y_N` + 2^(S−1) at `DATA_WIDTH`+1 bits.
  - If the carry bit is set, output all-ones (2^`OUT_WIDTH` − 1).
  - Otherwise output t[`DATA_WIDTH`−1:S].
  - Rounding is round-half-up.
- **Rounding register:** a kept sample is registered with `rnd_valid` one cycle after acceptance.
- **FIFO write** occurs when `rnd_valid` is high and the FIFO is not full, or is full with a pop in the same cycle.
  - Simultaneous push and pop are always legal; the count is unchanged.
  - Pop on empty does nothing.
- **Drop:** if `rnd_valid` is high, the FIFO is full, and there is no pop, the sample is discarded and `overflow` is set.
- **`overflow_clr`:**
  - Clears `overflow` on the next edge.
  - If a drop occurs in the same cycle as `overflow_clr`, set wins.
- **`z_N`** is the FIFO head, read combinationally from registered storage. It holds its value while `z_N_valid` is high and `z_N_ready` is low.

## Timing
- **Reset (`reset_n` low at an edge):**
  - `cnt` = 0, FIFO empty, `rnd_valid` = 0, `z_N_valid` = 0, `z_N` = 0, `overflow` = 0.
  - An in-flight rounded sample is discarded.
  - The first valid sample after reset is kept.
- **Latency:** a sample kept in cycle t appears on `z_N` with `z_N_valid` = 1 in cycle t+2 if the FIFO was empty, or behind the queued entries otherwise.
- **Throughput:** one kept sample per cycle at R = 1 when `z_N_ready` is held high.
- **`z_N_valid` deassertion:** goes low the cycle after the last entry pops.

## Structure
- Package `filter_pkg`:
  - function `round_sat(din)` parameterised by S.
  - localparams `FIFO_AW` = $clog2(`FIFO_DEPTH`) and the count width.
- Sub-module `filter_sync_fifo`:
  - Parameters `WIDTH` and `DEPTH`.
  - Ports `push`, `pop`, `din`, `dout`, `full`, `empty`.
  - Read/write pointers plus a count register.
  - Reset is active-low synchronous.
- Top level contains the phase counter, rounding register, overflow logic and the FIFO instance.

## Test plan
- **Reset:** hold `reset_n` low mid-stream with 3 entries queued, then release → `z_N_valid` = 0, `z_N` = 0, `overflow` = 0; the first post-reset sample is kept.
- **Rounding:** R = 1, inputs 0x1237, 0x1238, 0xFFF8, 0x0000, `z_N_ready` = 1 → `z_N` = 0x123, 0x124, 0xFFF (saturated), 0x000, each 2 cycles after its input.
- **Decimation:** R = 3, 9 consecutive valid samples 0x0010..0x0090 step 0x10 → output 0x001, 0x004, 0x007. With `y_N_valid` gapped every other cycle → the same outputs.
- **Ratio change:** R = 8 with `cnt` = 5, switch to R = 2 → the next sample wraps `cnt` to 0, and the following sample is kept.
- **Backpressure/overflow:** R = 1, `z_N_ready` = 0, 6 samples → 4 queued, 2 dropped, `overflow` = 1; the 4 queued values then drain in order once ready. Pulsing `overflow_clr` → 0. Clear coinciding with a drop → stays 1.
- **Full + pop:** FIFO full, push and pop in the same cycle → no drop, count stays 4, order preserved.
